inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/inst_fetch_fifo.sv | 63 ++++++
 rtl/inst_fetch.sv | 128 ++++++++++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the fetch stage.
// The entry carries a fault bit only when IF_MISALIGN_CHECK_EN is defined.
package inst_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_FAULT = 2'd2
  } if_state_t;

`ifdef IF_MISALIGN_CHECK_EN
  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1;
`else
  localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
`endif

  // Sequential fetch address; wraps modulo 2^32 with no flag.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO for {pc, inst} pairs: flush beats push/pop, a push into a full
// FIFO is taken only together with a pop, and the head is read from registers.
module inst_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is reset so the head never shows X, even when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns fetch_pc, drives inst_rom and feeds decode from
// a prefetch FIFO. Optional misaligned-redirect trapping via IF_MISALIGN_CHECK_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic [ADDR_WIDTH-1:0]   rom_addr_o,
  output logic                    rom_ce_o,
  input  logic [DATA_WIDTH-1:0]   rom_data_i,
  input  logic                    redirect_i,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [ADDR_WIDTH-1:0]   id_pc_o,
  output logic [DATA_WIDTH-1:0]   id_inst_o,
  output logic                    id_fault_o,
  output if_state_t               state_dbg,
  output logic [$clog2(DEPTH):0]  count_dbg
);

  if_state_t              state;
  if_state_t              state_next;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  fetch_pc_next;
  logic                   pop;
  logic                   push;
  logic                   marker_push;
  logic                   full;
  logic                   empty;
  logic [ENTRY_WIDTH-1:0] push_entry;
  logic [ENTRY_WIDTH-1:0] head_entry;

  // Decode handshake: the head transfers on a cycle where id_valid_o and
  // id_ready_i are both 1; a redirect in that cycle flushes it instead.
  assign id_valid_o = ~empty;
  assign pop        = id_valid_o & id_ready_i;
  assign rom_ce_o   = (state == IF_RUN) & ~redirect_i & (~full | pop);
  assign rom_addr_o = fetch_pc;
  assign push       = rom_ce_o | marker_push;
  assign state_dbg  = state;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned;
  logic marker_pending;

  assign misaligned  = (redirect_pc_i[1:0] != 2'b00);
  assign marker_push = (state == IF_FAULT) & marker_pending & ~redirect_i;
  assign push_entry  = marker_push ? {1'b1, fetch_pc, NOP_INST}
                                   : {1'b0, fetch_pc, rom_data_i};
  assign id_fault_o  = head_entry[ENTRY_WIDTH-1];

  // One marker per misaligned redirect; an aligned redirect cancels it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      marker_pending <= 1'b0;
    end else if (redirect_i) begin
      marker_pending <= misaligned;
    end else if (marker_push) begin
      marker_pending <= 1'b0;
    end
  end
`else
  assign marker_push = 1'b0;
  assign push_entry  = {fetch_pc, rom_data_i};
  assign id_fault_o  = 1'b0;
`endif

  assign id_pc_o   = head_entry[DATA_WIDTH +: ADDR_WIDTH];
  assign id_inst_o = head_entry[DATA_WIDTH-1:0];

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    unique case (state)
      IF_BOOT:  state_next = IF_RUN;
      IF_RUN:   state_next = IF_RUN;
`ifdef IF_MISALIGN_CHECK_EN
      IF_FAULT: state_next = IF_FAULT;
`else
      IF_FAULT: state_next = IF_RUN;
`endif
      default:  state_next = IF_BOOT;
    endcase
    // Redirect wins over sequential fetch, including during BOOT.
    if (redirect_i) begin
`ifdef IF_MISALIGN_CHECK_EN
      fetch_pc_next = redirect_pc_i;
      state_next    = misaligned ? IF_FAULT : IF_RUN;
`else
      fetch_pc_next = redirect_pc_i & ~ADDR_WIDTH'(3);
      state_next    = IF_RUN;
`endif
    end else if (rom_ce_o) begin
      fetch_pc_next = next_pc(fetch_pc);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IF_BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  inst_fetch_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count_dbg),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random ready/redirect traffic,
// checked every cycle against a queue-based model of the fetch stage.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_fault;
  if_state_t   state_dbg;
  logic [2:0]  count_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as {fault, pc, inst}.
  logic [64:0] exp_q[$];
  logic [31:0] m_pc;
  bit          booted;
  bit          faulted;
  bit          marker_due;
  logic        exp_ce;

  always #5 clk = ~clk;

  assign rom_data = rom_addr | 32'h13;

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .rom_addr_o    (rom_addr),
    .rom_ce_o      (rom_ce),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .id_fault_o    (id_fault),
    .state_dbg     (state_dbg),
    .count_dbg     (count_dbg)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic rdy, input logic redir);
    logic [64:0] head;
    if_state_t   exp_st;
    exp_ce = booted && !faulted && !redir &&
             (exp_q.size() < DEPTH || (exp_q.size() > 0 && rdy));
    exp_st = !booted ? IF_BOOT : (faulted ? IF_FAULT : IF_RUN);
    chk("rom_ce", rom_ce, exp_ce);
    chk("rom_addr", rom_addr, m_pc);
    chk("id_valid", id_valid, exp_q.size() > 0);
    chk("count", count_dbg, 65'(exp_q.size()));
    chk("state", state_dbg, exp_st);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      chk("id_pc", id_pc, head[63:32]);
      chk("id_inst", id_inst, head[31:0]);
      chk("id_fault", id_fault, head[64]);
    end else begin
      chk("head_known", $isunknown({id_pc, id_inst, id_fault}), 1'b0);
    end
`ifndef IF_MISALIGN_CHECK_EN
    chk("fault_tied", id_fault, 1'b0);
`endif
  endtask

  task automatic model_edge(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic [64:0] dropped;
    if (redir) begin
      exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
      m_pc       = tgt;
      faulted    = (tgt[1:0] != 2'b00);
      marker_due = faulted;
`else
      m_pc = {tgt[31:2], 2'b00};
`endif
    end else begin
      if (exp_q.size() > 0 && rdy) dropped = exp_q.pop_front();
      if (exp_ce) begin
        exp_q.push_back({1'b0, m_pc, m_pc | 32'h13});
        m_pc = m_pc + 32'd4;
      end else if (faulted && marker_due) begin
        exp_q.push_back({1'b1, m_pc, NOP_INST});
        marker_due = 1'b0;
      end
    end
    booted = 1'b1;
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    #1;
    check_outputs(rdy, redir);
    @(posedge clk);
    model_edge(rdy, redir, tgt);
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks reset values without a clock edge,
  // then releases on the next falling edge.
  task automatic apply_reset();
    redirect = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    m_pc       = RESET_PC;
    booted     = 1'b0;
    faulted    = 1'b0;
    marker_due = 1'b0;
    #1;
    chk("rst_addr", rom_addr, RESET_PC);
    chk("rst_ce", rom_ce, 1'b0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_fault", id_fault, 1'b0);
    chk("rst_state", state_dbg, IF_BOOT);
    chk("rst_count", count_dbg, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rst_n       = 1'b0;

    // Reset and free-run: pcs 0,4,8,12 from cycle 2.
    apply_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("free_pc", id_pc, 32'(4 * k));
      chk("free_inst", id_inst, 32'h13 + 32'(4 * k));
      step(1'b1, 1'b0, 32'h0);
    end

    // Back-pressure from reset, then release.
    apply_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("bp_head", id_pc, 32'h0);
    chk("bp_count", count_dbg, 3'd4);
    chk("bp_ce", rom_ce, 1'b0);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Redirect with a full FIFO and a simultaneous pop.
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h100);
    chk("redir_n1_valid", id_valid, 1'b0);
    chk("redir_n1_addr", rom_addr, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_n2_pc", id_pc, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_n3_pc", id_pc, 32'h104);
    step(1'b1, 1'b0, 32'h0);

    // PC wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then an aligned one.
    step(1'b1, 1'b1, 32'h102);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Random traffic.
    repeat (300) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      step(rdy, redir, tgt);
    end

    // Asynchronous reset mid-stream, then a redirect during BOOT.
    step(1'b1, 1'b1, 32'h300);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    #2;
    apply_reset();
    step(1'b1, 1'b1, 32'h40);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
